// File: rtl/axi3_hp_writer.sv
// axi3_hp_writer: drains BURST_SIZE words from an FWFT FIFO into one AXI3 INCR write burst
module axi3_hp_writer #(
    parameter int BURST_SIZE = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [28:0] DMA_WR_ADDR,
    input  logic        DMA_START,
    output logic        DMA_READY,
    output logic        DMA_DONE,
    output logic        DMA_ERROR,
    input  logic [31:0] DMA_WR_DATA,
    input  logic        DMA_WR_DATA_AVAIL,
    output logic        DMA_WR_DATA_RD,
    input  logic        m00_axi_awready,
    output logic [31:0] m00_axi_awaddr,
    output logic [3:0]  m00_axi_awlen,
    output logic [2:0]  m00_axi_awsize,
    output logic [1:0]  m00_axi_awburst,
    output logic        m00_axi_awvalid,
    input  logic        m00_axi_wready,
    output logic [31:0] m00_axi_wdata,
    output logic [3:0]  m00_axi_wstrb,
    output logic        m00_axi_wlast,
    output logic        m00_axi_wvalid,
    input  logic        m00_axi_bvalid,
    input  logic [1:0]  m00_axi_bresp,
    output logic        m00_axi_bready
);
    typedef enum logic [1:0] {IDLE, BURST, RESP} state_t;
    state_t      state;
    logic [28:0] addr;
    logic [3:0]  count;
    logic        aw_done;
    logic        w_done;
    logic        aw_hs;
    logic        w_hs;
    logic        last_hs;
    // w_done stops further beats once the last one is taken, since a 4-bit count wraps at 16
    assign m00_axi_wvalid  = (state == BURST) & ~w_done & DMA_WR_DATA_AVAIL;
    assign m00_axi_wlast   = m00_axi_wvalid & (count == 4'(BURST_SIZE - 1));
    assign m00_axi_wdata   = DMA_WR_DATA;
    assign m00_axi_wstrb   = 4'hF;
    assign m00_axi_awaddr  = {addr, 3'b000};
    assign m00_axi_awlen   = 4'(BURST_SIZE - 1);
    assign m00_axi_awsize  = 3'b010;
    assign m00_axi_awburst = 2'b01;
    assign m00_axi_bready  = (state == RESP);
    assign DMA_READY       = (state == IDLE);
    assign aw_hs           = m00_axi_awvalid & m00_axi_awready;
    assign w_hs            = m00_axi_wvalid & m00_axi_wready;
    assign last_hs         = w_hs & m00_axi_wlast;
    assign DMA_WR_DATA_RD  = w_hs;
    // burst sequencer: address and data channels progress independently, response closes the burst
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state           <= IDLE;
            addr            <= '0;
            count           <= '0;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            m00_axi_awvalid <= 1'b0;
            DMA_DONE        <= 1'b0;
            DMA_ERROR       <= 1'b0;
        end else begin
            DMA_DONE <= 1'b0;
            case (state)
                IDLE: if (DMA_START) begin
                    addr            <= DMA_WR_ADDR;
                    DMA_ERROR       <= 1'b0;
                    m00_axi_awvalid <= 1'b1;
                    count           <= '0;
                    aw_done         <= 1'b0;
                    w_done          <= 1'b0;
                    state           <= BURST;
                end
                BURST: begin
                    if (aw_hs) begin
                        m00_axi_awvalid <= 1'b0;
                        aw_done         <= 1'b1;
                    end
                    if (w_hs) count <= count + 4'd1;
                    if (last_hs) w_done <= 1'b1;
                    if ((aw_done | aw_hs) & (w_done | last_hs)) state <= RESP;
                end
                RESP: if (m00_axi_bvalid) begin
                    DMA_ERROR <= (m00_axi_bresp != 2'b00);
                    DMA_DONE  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi3_hp_writer.sv
// tb_axi3_hp_writer: directed tests of the AXI3 HP burst writer
module tb_axi3_hp_writer;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [28:0] DMA_WR_ADDR = '0;
    logic        DMA_START = 1'b0;
    logic        start1 = 1'b0;
    logic        DMA_READY, DMA_DONE, DMA_ERROR, DMA_WR_DATA_RD;
    logic [31:0] DMA_WR_DATA;
    logic        avail_en = 1'b1;
    logic        m00_axi_awready = 1'b1;
    logic [31:0] m00_axi_awaddr;
    logic [3:0]  m00_axi_awlen;
    logic [2:0]  m00_axi_awsize;
    logic [1:0]  m00_axi_awburst;
    logic        m00_axi_awvalid;
    logic        m00_axi_wready = 1'b1;
    logic [31:0] m00_axi_wdata;
    logic [3:0]  m00_axi_wstrb;
    logic        m00_axi_wlast, m00_axi_wvalid;
    logic        b_en = 1'b1;
    logic [1:0]  m00_axi_bresp = 2'b00;
    logic        m00_axi_bready;
    logic        s_ready, s_done, s_error, s_rd, s_awvalid, s_wlast, s_wvalid, s_bready;
    logic [31:0] s_awaddr, s_wdata;
    logic [3:0]  s_awlen, s_wstrb;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst;
    logic [31:0] fifo_mem [0:255];
    logic [7:0]  rd_ptr = '0;
    int vectors = 0;
    int miscompares = 0;
    int pops, nlast, last_at, aws, early_last;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_data = '0;

    assign DMA_WR_DATA = fifo_mem[rd_ptr];

    axi3_hp_writer #(.BURST_SIZE(8)) dut (
        .CLK(CLK), .RESET(RESET), .DMA_WR_ADDR(DMA_WR_ADDR), .DMA_START(DMA_START),
        .DMA_READY(DMA_READY), .DMA_DONE(DMA_DONE), .DMA_ERROR(DMA_ERROR),
        .DMA_WR_DATA(DMA_WR_DATA), .DMA_WR_DATA_AVAIL(avail_en), .DMA_WR_DATA_RD(DMA_WR_DATA_RD),
        .m00_axi_awready(m00_axi_awready), .m00_axi_awaddr(m00_axi_awaddr), .m00_axi_awlen(m00_axi_awlen),
        .m00_axi_awsize(m00_axi_awsize), .m00_axi_awburst(m00_axi_awburst), .m00_axi_awvalid(m00_axi_awvalid),
        .m00_axi_wready(m00_axi_wready), .m00_axi_wdata(m00_axi_wdata), .m00_axi_wstrb(m00_axi_wstrb),
        .m00_axi_wlast(m00_axi_wlast), .m00_axi_wvalid(m00_axi_wvalid), .m00_axi_bvalid(b_en),
        .m00_axi_bresp(m00_axi_bresp), .m00_axi_bready(m00_axi_bready)
    );

    axi3_hp_writer #(.BURST_SIZE(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .DMA_WR_ADDR(DMA_WR_ADDR), .DMA_START(start1),
        .DMA_READY(s_ready), .DMA_DONE(s_done), .DMA_ERROR(s_error),
        .DMA_WR_DATA(DMA_WR_DATA), .DMA_WR_DATA_AVAIL(avail_en), .DMA_WR_DATA_RD(s_rd),
        .m00_axi_awready(m00_axi_awready), .m00_axi_awaddr(s_awaddr), .m00_axi_awlen(s_awlen),
        .m00_axi_awsize(s_awsize), .m00_axi_awburst(s_awburst), .m00_axi_awvalid(s_awvalid),
        .m00_axi_wready(m00_axi_wready), .m00_axi_wdata(s_wdata), .m00_axi_wstrb(s_wstrb),
        .m00_axi_wlast(s_wlast), .m00_axi_wvalid(s_wvalid), .m00_axi_bvalid(b_en),
        .m00_axi_bresp(m00_axi_bresp), .m00_axi_bready(s_bready)
    );

    always #5 CLK = ~CLK;

    // FWFT FIFO model: head advances on each pop
    always @(posedge CLK) if (DMA_WR_DATA_RD === 1'b1) rd_ptr <= rd_ptr + 8'd1;

    // W-channel monitor, sampled mid-cycle
    always @(negedge CLK) begin
        if (RESET) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                vectors++;
                if (m00_axi_wvalid !== 1'b1 || m00_axi_wdata !== prev_data) begin
                    miscompares++;
                    $display("FAIL w_stable: wvalid=%b wdata=%h, required 1 and %h", m00_axi_wvalid, m00_axi_wdata, prev_data);
                end
            end
            if (m00_axi_wlast === 1'b1 && pops != 7) early_last++;
            if (m00_axi_wvalid === 1'b1 && m00_axi_wready === 1'b1) begin
                pops++;
                if (m00_axi_wlast === 1'b1) begin
                    nlast++;
                    last_at = pops;
                end
            end
            if (m00_axi_awvalid === 1'b1 && m00_axi_awready === 1'b1) aws++;
            stall_prev = m00_axi_wvalid & ~m00_axi_wready;
            prev_data = m00_axi_wdata;
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_mon;
        pops = 0; nlast = 0; last_at = 0; aws = 0; early_last = 0;
    endtask

    task automatic start_burst(input logic [28:0] a);
        DMA_WR_ADDR = a;
        DMA_START = 1'b1;
        tick();
        DMA_START = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 60 && DMA_DONE !== 1'b1) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        #2;
        vectors++;
        if (DMA_READY !== 1'b1 || DMA_DONE !== 1'b0 || DMA_ERROR !== 1'b0 || m00_axi_awvalid !== 1'b0 || m00_axi_wvalid !== 1'b0 || m00_axi_bready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: ready=%b done=%b err=%b awv=%b wv=%b bready=%b, required 1 0 0 0 0 0", DMA_READY, DMA_DONE, DMA_ERROR, m00_axi_awvalid, m00_axi_wvalid, m00_axi_bready);
        end
        tick();
        RESET = 1'b0;
        tick();
        vectors++;
        if (DMA_READY !== 1'b1 || m00_axi_awvalid !== 1'b0 || m00_axi_wvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: ready=%b awv=%b wv=%b, required 1 0 0", DMA_READY, m00_axi_awvalid, m00_axi_wvalid);
        end
        vectors++;
        if (m00_axi_awsize !== 3'b010 || m00_axi_awburst !== 2'b01 || m00_axi_wstrb !== 4'hF || m00_axi_awlen !== 4'h7) begin
            miscompares++;
            $display("FAIL constants: awsize=%b awburst=%b wstrb=%h awlen=%h, required 010 01 f 7", m00_axi_awsize, m00_axi_awburst, m00_axi_wstrb, m00_axi_awlen);
        end
    endtask

    task automatic test_burst;
        reset_mon();
        m00_axi_awready = 1'b1; m00_axi_wready = 1'b1; avail_en = 1'b1; b_en = 1'b1; m00_axi_bresp = 2'b00;
        start_burst(29'h0100_0000);
        for (int c = 1; c <= 11; c++) begin
            if (c == 1) begin
                vectors++;
                if (m00_axi_awvalid !== 1'b1 || m00_axi_awaddr !== 32'h0800_0000 || m00_axi_awlen !== 4'h7) begin
                    miscompares++;
                    $display("FAIL burst_aw: awv=%b awaddr=%h awlen=%h, required 1 08000000 7", m00_axi_awvalid, m00_axi_awaddr, m00_axi_awlen);
                end
                vectors++;
                if (m00_axi_wvalid !== 1'b1 || m00_axi_wdata !== fifo_mem[rd_ptr]) begin
                    miscompares++;
                    $display("FAIL burst_w0: wv=%b wdata=%h, required 1 %h", m00_axi_wvalid, m00_axi_wdata, fifo_mem[rd_ptr]);
                end
            end
            vectors++;
            if (DMA_DONE !== (c == 10)) begin
                miscompares++;
                $display("FAIL burst_done cycle %0d: got %b required %b", c, DMA_DONE, (c == 10));
            end
            if (c == 10) begin
                vectors++;
                if (DMA_READY !== 1'b1) begin
                    miscompares++;
                    $display("FAIL burst_ready: got %b required 1", DMA_READY);
                end
            end
            tick();
        end
        vectors++;
        if (pops != 8 || nlast != 1 || last_at != 8 || aws != 1 || early_last != 0) begin
            miscompares++;
            $display("FAIL burst_beats: pops=%0d nlast=%0d last_at=%0d aws=%0d early=%0d, required 8 1 8 1 0", pops, nlast, last_at, aws, early_last);
        end
    endtask

    task automatic test_reset_mid;
        reset_mon();
        m00_axi_awready = 1'b0;
        start_burst(29'h0123_4567);
        for (int c = 0; c < 50 && pops < 3; c++) tick();
        vectors++;
        if (pops != 3 || m00_axi_awvalid !== 1'b1 || m00_axi_wvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre: pops=%0d awv=%b wv=%b, required 3 1 1", pops, m00_axi_awvalid, m00_axi_wvalid);
        end
        RESET = 1'b1;
        #1;
        vectors++;
        if (m00_axi_awvalid !== 1'b0 || m00_axi_wvalid !== 1'b0 || m00_axi_bready !== 1'b0 || DMA_READY !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset: awv=%b wv=%b bready=%b ready=%b, required 0 0 0 1", m00_axi_awvalid, m00_axi_wvalid, m00_axi_bready, DMA_READY);
        end
        tick();
        RESET = 1'b0;
        m00_axi_awready = 1'b1;
        tick();
        tick();
        vectors++;
        if (DMA_DONE !== 1'b0 || DMA_READY !== 1'b1 || m00_axi_awvalid !== 1'b0 || pops != 3) begin
            miscompares++;
            $display("FAIL mid_after: done=%b ready=%b awv=%b pops=%0d, required 0 1 0 3", DMA_DONE, DMA_READY, m00_axi_awvalid, pops);
        end
    endtask

    task automatic test_late_aw;
        reset_mon();
        m00_axi_awready = 1'b0; m00_axi_wready = 1'b1; b_en = 1'b1;
        start_burst(29'h0000_0010);
        for (int c = 1; c <= 12; c++) begin
            if (c >= 9) begin
                vectors++;
                if (pops != 8 || m00_axi_bready !== 1'b0 || DMA_READY !== 1'b0 || m00_axi_awvalid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL late_wait cycle %0d: pops=%0d bready=%b ready=%b awv=%b, required 8 0 0 1", c, pops, m00_axi_bready, DMA_READY, m00_axi_awvalid);
                end
            end
            tick();
        end
        m00_axi_awready = 1'b1;
        tick();
        vectors++;
        if (m00_axi_bready !== 1'b1 || m00_axi_awvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL late_resp: bready=%b awv=%b, required 1 0", m00_axi_bready, m00_axi_awvalid);
        end
        tick();
        vectors++;
        if (DMA_DONE !== 1'b1 || aws != 1 || last_at != 8) begin
            miscompares++;
            $display("FAIL late_done: done=%b aws=%0d last_at=%0d, required 1 1 8", DMA_DONE, aws, last_at);
        end
        tick();
    endtask

    task automatic test_underrun;
        int cnt;
        logic dropped;
        reset_mon();
        cnt = 0; dropped = 1'b0;
        m00_axi_awready = 1'b1; m00_axi_wready = 1'b1; avail_en = 1'b1; b_en = 1'b1;
        start_burst(29'h0000_0200);
        for (int c = 0; c < 80 && DMA_DONE !== 1'b1; c++) begin
            if (!avail_en) begin
                vectors++;
                if (m00_axi_wvalid !== 1'b0 || DMA_WR_DATA_RD !== 1'b0) begin
                    miscompares++;
                    $display("FAIL underrun_idle: wv=%b rd=%b, required 0 0", m00_axi_wvalid, DMA_WR_DATA_RD);
                end
            end
            m00_axi_wready = ~m00_axi_wready;
            if (!dropped && pops == 4) begin
                avail_en = 1'b0; dropped = 1'b1; cnt = 5;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) avail_en = 1'b1;
            end
            tick();
        end
        vectors++;
        if (DMA_DONE !== 1'b1 || dropped !== 1'b1 || pops != 8 || nlast != 1 || last_at != 8 || early_last != 0) begin
            miscompares++;
            $display("FAIL underrun_end: done=%b dropped=%b pops=%0d nlast=%0d last_at=%0d early=%0d, required 1 1 8 1 8 0", DMA_DONE, dropped, pops, nlast, last_at, early_last);
        end
        m00_axi_wready = 1'b1; avail_en = 1'b1;
        tick();
    endtask

    task automatic test_error;
        int n;
        reset_mon();
        m00_axi_bresp = 2'b10;
        start_burst(29'h0000_0300);
        wait_done(n);
        vectors++;
        if (DMA_DONE !== 1'b1 || DMA_ERROR !== 1'b1) begin
            miscompares++;
            $display("FAIL err_done: done=%b err=%b, required 1 1", DMA_DONE, DMA_ERROR);
        end
        tick();
        tick();
        vectors++;
        if (DMA_DONE !== 1'b0 || DMA_ERROR !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: done=%b err=%b, required 0 1", DMA_DONE, DMA_ERROR);
        end
        m00_axi_bresp = 2'b00;
        start_burst(29'h0000_0400);
        vectors++;
        if (DMA_ERROR !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: got %b required 0", DMA_ERROR);
        end
        wait_done(n);
        vectors++;
        if (DMA_DONE !== 1'b1 || DMA_ERROR !== 1'b0) begin
            miscompares++;
            $display("FAIL err_okay: done=%b err=%b, required 1 0", DMA_DONE, DMA_ERROR);
        end
        tick();
    endtask

    task automatic test_busy_start;
        int n;
        reset_mon();
        b_en = 1'b0; m00_axi_awready = 1'b0;
        start_burst(29'h0AAA_AAAA);
        tick();
        DMA_WR_ADDR = 29'h1555_5555;
        DMA_START = 1'b1;
        tick();
        DMA_START = 1'b0;
        vectors++;
        if (m00_axi_awaddr !== 32'h5555_5550 || DMA_READY !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_burst: awaddr=%h ready=%b, required 55555550 0", m00_axi_awaddr, DMA_READY);
        end
        m00_axi_awready = 1'b1;
        for (int c = 0; c < 40 && m00_axi_bready !== 1'b1; c++) tick();
        DMA_START = 1'b1;
        tick();
        DMA_START = 1'b0;
        vectors++;
        if (m00_axi_bready !== 1'b1 || m00_axi_awvalid !== 1'b0 || m00_axi_awaddr !== 32'h5555_5550) begin
            miscompares++;
            $display("FAIL busy_resp: bready=%b awv=%b awaddr=%h, required 1 0 55555550", m00_axi_bready, m00_axi_awvalid, m00_axi_awaddr);
        end
        tick();
        b_en = 1'b1;
        wait_done(n);
        vectors++;
        if (DMA_DONE !== 1'b1 || aws != 1 || pops != 8) begin
            miscompares++;
            $display("FAIL busy_done: done=%b aws=%0d pops=%0d, required 1 1 8", DMA_DONE, aws, pops);
        end
        tick();
        tick();
        vectors++;
        if (m00_axi_awvalid !== 1'b0 || DMA_READY !== 1'b1 || aws != 1) begin
            miscompares++;
            $display("FAIL busy_idle: awv=%b ready=%b aws=%0d, required 0 1 1", m00_axi_awvalid, DMA_READY, aws);
        end
    endtask

    task automatic test_simultaneous;
        reset_mon();
        m00_axi_awready = 1'b0; m00_axi_wready = 1'b1; avail_en = 1'b1; b_en = 1'b1;
        start_burst(29'h0000_0500);
        for (int c = 1; c < 8; c++) tick();
        m00_axi_awready = 1'b1;
        vectors++;
        if (m00_axi_bready !== 1'b0 || m00_axi_wlast !== 1'b1 || m00_axi_awvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_pre: bready=%b wlast=%b awv=%b, required 0 1 1", m00_axi_bready, m00_axi_wlast, m00_axi_awvalid);
        end
        tick();
        vectors++;
        if (m00_axi_bready !== 1'b1 || m00_axi_awvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_resp: bready=%b awv=%b, required 1 0", m00_axi_bready, m00_axi_awvalid);
        end
        tick();
        vectors++;
        if (DMA_DONE !== 1'b1 || aws != 1 || pops != 8) begin
            miscompares++;
            $display("FAIL simul_done: done=%b aws=%0d pops=%0d, required 1 1 8", DMA_DONE, aws, pops);
        end
        tick();
    endtask

    task automatic test_single;
        m00_axi_awready = 1'b1; m00_axi_wready = 1'b1; avail_en = 1'b1; b_en = 1'b1;
        vectors++;
        if (s_awlen !== 4'h0 || s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_idle: awlen=%h ready=%b, required 0 1", s_awlen, s_ready);
        end
        DMA_WR_ADDR = 29'h0000_0007;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        vectors++;
        if (s_awvalid !== 1'b1 || s_wvalid !== 1'b1 || s_wlast !== 1'b1 || s_rd !== 1'b1 || s_awaddr !== 32'h0000_0038) begin
            miscompares++;
            $display("FAIL single_beat: awv=%b wv=%b wlast=%b rd=%b awaddr=%h, required 1 1 1 1 00000038", s_awvalid, s_wvalid, s_wlast, s_rd, s_awaddr);
        end
        tick();
        vectors++;
        if (s_bready !== 1'b1 || s_wvalid !== 1'b0 || s_awvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_resp: bready=%b wv=%b awv=%b, required 1 0 0", s_bready, s_wvalid, s_awvalid);
        end
        tick();
        vectors++;
        if (s_done !== 1'b1 || s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_done: done=%b ready=%b, required 1 1", s_done, s_ready);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) fifo_mem[i] = 32'hA500_0000 + 32'(i * 32'h0001_0101);
        reset_mon();
        test_reset();
        test_burst();
        test_reset_mid();
        test_late_aw();
        test_underrun();
        test_error();
        test_busy_start();
        test_simultaneous();
        test_single();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/axi3_hp_writer.md
Name: axi3_hp_writer

Overview:
- AXI3 HP-port burst write master. It is the DMA write-side companion of the LCD controller's burst reader.
- Takes one start command with a 29-bit 8-byte-aligned address and drains BURST_SIZE 32-bit words from a first-word-fall-through (FWFT) FIFO into one INCR write burst.
- Waits for the write response, then reports completion and error status.
- Sits between a producer-side FWFT FIFO and a Zynq S_AXI_HP slave port.

Parameters:
- BURST_SIZE, 8, beats per burst, legal range 1..16 (AXI3 AWLEN limit); awlen = BURST_SIZE-1.

Ports:
- CLK  in  1  DMA/FIFO clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- DMA_WR_ADDR  in  29  burst start address in 8-byte units; sampled on accepted DMA_START.
- DMA_START  in  1  one-cycle start pulse; honoured only when DMA_READY=1.
- DMA_READY  out  1  1 when idle and able to accept DMA_START.
- DMA_DONE  out  1  one-cycle pulse when the write response is received.
- DMA_ERROR  out  1  sticky; 1 if the last burst's BRESP was not OKAY; cleared on next accepted DMA_START.
- DMA_WR_DATA  in  32  FIFO head word (FWFT).
- DMA_WR_DATA_AVAIL  in  1  FIFO not empty.
- DMA_WR_DATA_RD  out  1  FIFO pop strobe; equals the W handshake (wvalid & wready).
- m00_axi_awready  in  1  AW ready.
- m00_axi_awaddr  out  32  {latched DMA_WR_ADDR, 3'b000}.
- m00_axi_awlen  out  4  BURST_SIZE-1, constant.
- m00_axi_awsize  out  3  3'b010, constant (4-byte beats).
- m00_axi_awburst  out  2  2'b01, constant (INCR).
- m00_axi_awvalid  out  1  AW valid.
- m00_axi_wready  in  1  W ready.
- m00_axi_wdata  out  32  DMA_WR_DATA, passed through combinationally.
- m00_axi_wstrb  out  4  4'hF, constant.
- m00_axi_wlast  out  1  1 on the final beat.
- m00_axi_wvalid  out  1  W valid.
- m00_axi_bvalid  in  1  B valid.
- m00_axi_bresp  in  2  B response.
- m00_axi_bready  out  1  B ready.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; DMA_READY=1; DMA_DONE=0; DMA_ERROR=0.
  - awvalid=0; wvalid=0; bready=0; beat counter=0; aw_done=0.
  - Reset mid-burst abandons the burst with no completion. The system resets the interconnect together with this block.
- States: IDLE, BURST, RESP.
- IDLE:
  - DMA_READY=1.
  - On DMA_START: latch the address, clear DMA_ERROR, set awvalid=1 (registered, visible the next cycle), go to BURST.
  - DMA_START in BURST or RESP is ignored.
- BURST, address channel:
  - awvalid held with awaddr stable until awready is sampled high.
  - Then awvalid=0 and aw_done=1.
- BURST, data channel:
  - wvalid = DMA_WR_DATA_AVAIL, gated to BURST and to beats < BURST_SIZE.
  - AW and W proceed independently; W beats may be accepted before, with or after AW acceptance.
  - The FWFT FIFO is popped only by this block, so once wvalid rises it stays high with stable data until wready.
  - The beat counter (4 bits) increments on each W handshake.
  - wlast = wvalid & (count == BURST_SIZE-1).
- BURST exit: leave for RESP when both are true, whether they occur in the same cycle or different cycles:
  - aw_done is set, or the AW handshake happens this cycle;
  - the last-beat handshake has happened, or happens this cycle.
- RESP:
  - bready=1.
  - On bvalid: DMA_ERROR <= (bresp != 2'b00); DMA_DONE pulses for 1 cycle on the next cycle; state=IDLE, with DMA_READY=1 on that same cycle.
- Latency, ideal slave with all readies high and FIFO full:
  - DMA_START at cycle 0.
  - AW plus beat 0 at cycle 1.
  - Last beat at cycle BURST_SIZE.
  - bvalid at cycle BURST_SIZE+1 at the earliest.
  - DMA_DONE and DMA_READY at cycle BURST_SIZE+2.
- FIFO underrun: wvalid drops between beats, and the burst stalls without ending until more data arrives. There is no timeout.
- BURST_SIZE=1: beat 0 carries wlast=1.

Test Plan:
- Reset mid-burst:
  - Stimulus: BURST_SIZE=8, FIFO full, all readies high; DMA_START with address 29'h0100_0000; then a second burst with RESET asserted after 3 beats.
  - Required: awaddr 32'h0800_0000 and awlen 4'h7 on cycle 1; 8 pops; wlast only on the 8th beat; DMA_DONE on cycle 10.
  - Required on reset: awvalid, wvalid and bready drop in the same cycle and DMA_READY=1.
- Late AW: awready held low for 12 cycles while wready=1.
  - Required: all 8 beats complete first; state remains BURST until the AW handshake; then RESP.
- W stall and underrun: wready toggles 1/0 each cycle and DMA_WR_DATA_AVAIL drops for 5 cycles after beat 3.
  - Required: wdata stable while wvalid & ~wready; exactly 8 pops; no wlast before beat 7.
- Error response: bresp=2'b10 (SLVERR).
  - Required: DMA_ERROR=1 with DMA_DONE; DMA_ERROR clears on the next DMA_START, whose burst returns OKAY and keeps DMA_ERROR=0.
- Start while busy: DMA_START pulses during BURST and during RESP.
  - Required: no extra AW; the latched address is unchanged; beat count stays 8.
- Single-beat build (BURST_SIZE=1).
  - Required: awlen=0; one beat with wlast=1.
- Simultaneous final events: AW handshake and last-beat handshake in the same cycle.
  - Required: direct transition to RESP.
